// File: rtl/sram_port_arbiter_pkg.sv
// Shared SRAM geometry, requester indices and lock-owner encoding for the
// single-port SRAM arbiter.
package sram_port_arbiter_pkg;

  localparam int unsigned SRAM_DW    = 32;
  localparam int unsigned SRAM_MASKW = 4;
  localparam int unsigned REQ_CORE   = 0;
  localparam int unsigned REQ_HOST   = 1;
  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned STARVE_CW  = 8;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_CORE = 2'd1,
    LOCK_HOST = 2'd2
  } lock_own_e;

endpackage : sram_port_arbiter_pkg

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for the 1RW port of one SRAM macro: same-cycle grant,
// active-low macro controls and one-cycle-later read valid to the winner.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned AW           = 8,
  parameter int unsigned FIXED_PRIO   = 0,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic                  r0_lock,
  input  logic [SRAM_MASKW-1:0] r0_wmask,
  input  logic [AW-1:0]         r0_addr,
  input  logic [SRAM_DW-1:0]    r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [SRAM_DW-1:0]    r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic                  r1_lock,
  input  logic [SRAM_MASKW-1:0] r1_wmask,
  input  logic [AW-1:0]         r1_addr,
  input  logic [SRAM_DW-1:0]    r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [SRAM_DW-1:0]    r1_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [SRAM_MASKW-1:0] sram_wmask0,
  output logic [AW-1:0]         sram_addr0,
  output logic [SRAM_DW-1:0]    sram_din0,
  input  logic [SRAM_DW-1:0]    sram_dout0
);

  localparam logic [STARVE_CW-1:0] STARVE_MAX = STARVE_CW'(STARVE_LIMIT);

  lock_own_e              lock_own_q, lock_own_d;
  logic                   rr_ptr_q, rr_ptr_d;
  logic [STARVE_CW-1:0]   starve_cnt_q, starve_cnt_d;
  logic [NUM_REQ-1:0]     rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0]     gnt;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      lock_own_q   <= LOCK_NONE;
      rr_ptr_q     <= 1'b0;
      starve_cnt_q <= '0;
      rvalid_q     <= '0;
    end else begin
      lock_own_q   <= lock_own_d;
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      rvalid_q     <= rvalid_d;
    end
  end

  // Grant priority: live lock, starvation override, lone requester, tie-break.
  always_comb begin
    gnt = '0;
    if (!wb_rst_i) begin
      if (lock_own_q == LOCK_CORE && r0_lock) begin
        gnt[REQ_CORE] = r0_req;
      end else if (lock_own_q == LOCK_HOST && r1_lock) begin
        gnt[REQ_HOST] = r1_req;
      end else if (FIXED_PRIO != 0 && starve_cnt_q == STARVE_MAX && r1_req) begin
        gnt[REQ_HOST] = 1'b1;
      end else if (r0_req && r1_req) begin
        if (FIXED_PRIO == 0 && rr_ptr_q) gnt[REQ_HOST] = 1'b1;
        else                             gnt[REQ_CORE] = 1'b1;
      end else begin
        gnt[REQ_CORE] = r0_req;
        gnt[REQ_HOST] = r1_req;
      end
    end
  end

  // Next-state for lock owner, round-robin pointer, starvation count, read valid.
  always_comb begin
    lock_own_d   = lock_own_q;
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    rvalid_d     = '0;

    if (lock_own_q == LOCK_CORE && !r0_lock) lock_own_d = LOCK_NONE;
    if (lock_own_q == LOCK_HOST && !r1_lock) lock_own_d = LOCK_NONE;
    if (gnt[REQ_CORE] && r0_lock)      lock_own_d = LOCK_CORE;
    else if (gnt[REQ_HOST] && r1_lock) lock_own_d = LOCK_HOST;

    if (gnt[REQ_CORE])      rr_ptr_d = 1'b1;
    else if (gnt[REQ_HOST]) rr_ptr_d = 1'b0;

    if (FIXED_PRIO == 0 || !r1_req || gnt[REQ_HOST]) starve_cnt_d = '0;
    else if (starve_cnt_q < STARVE_MAX) starve_cnt_d = starve_cnt_q + STARVE_CW'(1);

    rvalid_d[REQ_CORE] = gnt[REQ_CORE] & ~r0_we;
    rvalid_d[REQ_HOST] = gnt[REQ_HOST] & ~r1_we;
  end

  // Macro port mux; idle values whenever nobody is granted.
  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (gnt[REQ_HOST]) begin
      sram_csb0   = 1'b0;
      sram_web0   = ~r1_we;
      sram_wmask0 = r1_wmask;
      sram_addr0  = r1_addr;
      sram_din0   = r1_wdata;
    end else if (gnt[REQ_CORE]) begin
      sram_csb0   = 1'b0;
      sram_web0   = ~r0_we;
      sram_wmask0 = r0_wmask;
      sram_addr0  = r0_addr;
      sram_din0   = r0_wdata;
    end
  end

  assign r0_gnt    = gnt[REQ_CORE];
  assign r1_gnt    = gnt[REQ_HOST];
  assign r0_rvalid = rvalid_q[REQ_CORE];
  assign r1_rvalid = rvalid_q[REQ_HOST];
  assign r0_rdata  = sram_dout0;
  assign r1_rdata  = sram_dout0;

endmodule : sram_port_arbiter

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: round-robin arbiter against a behavioural SRAM, plus a
// fixed-priority instance for the starvation override.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Round-robin instance signals.
  logic        a0_req = 0, a0_we = 0, a0_lock = 0;
  logic [3:0]  a0_wmask = 0;
  logic [7:0]  a0_addr = 0;
  logic [31:0] a0_wdata = 0;
  logic        a1_req = 0, a1_we = 0, a1_lock = 0;
  logic [3:0]  a1_wmask = 0;
  logic [7:0]  a1_addr = 0;
  logic [31:0] a1_wdata = 0;
  logic        a0_gnt, a0_rvalid, a1_gnt, a1_rvalid;
  logic [31:0] a0_rdata, a1_rdata;
  logic        a_csb, a_web;
  logic [3:0]  a_wmask;
  logic [7:0]  a_addr;
  logic [31:0] a_din, a_dout;

  // Fixed-priority instance signals.
  logic        f0_req = 0, f1_req = 0;
  logic        f0_gnt, f0_rvalid, f1_gnt, f1_rvalid;
  logic [31:0] f0_rdata, f1_rdata;
  logic        f_csb, f_web;
  logic [3:0]  f_wmask;
  logic [7:0]  f_addr;
  logic [31:0] f_din;
  logic [31:0] f_dout = 0;

  sram_port_arbiter #(.AW(8), .FIXED_PRIO(0), .STARVE_LIMIT(8)) u_rr (
    .clk(clk), .wb_rst_i(rst),
    .r0_req(a0_req), .r0_we(a0_we), .r0_lock(a0_lock), .r0_wmask(a0_wmask),
    .r0_addr(a0_addr), .r0_wdata(a0_wdata), .r0_gnt(a0_gnt),
    .r0_rvalid(a0_rvalid), .r0_rdata(a0_rdata),
    .r1_req(a1_req), .r1_we(a1_we), .r1_lock(a1_lock), .r1_wmask(a1_wmask),
    .r1_addr(a1_addr), .r1_wdata(a1_wdata), .r1_gnt(a1_gnt),
    .r1_rvalid(a1_rvalid), .r1_rdata(a1_rdata),
    .sram_csb0(a_csb), .sram_web0(a_web), .sram_wmask0(a_wmask),
    .sram_addr0(a_addr), .sram_din0(a_din), .sram_dout0(a_dout)
  );

  sram_port_arbiter #(.AW(8), .FIXED_PRIO(1), .STARVE_LIMIT(3)) u_fp (
    .clk(clk), .wb_rst_i(rst),
    .r0_req(f0_req), .r0_we(1'b0), .r0_lock(1'b0), .r0_wmask(4'h0),
    .r0_addr(8'h01), .r0_wdata(32'h0), .r0_gnt(f0_gnt),
    .r0_rvalid(f0_rvalid), .r0_rdata(f0_rdata),
    .r1_req(f1_req), .r1_we(1'b0), .r1_lock(1'b0), .r1_wmask(4'h0),
    .r1_addr(8'h02), .r1_wdata(32'h0), .r1_gnt(f1_gnt),
    .r1_rvalid(f1_rvalid), .r1_rdata(f1_rdata),
    .sram_csb0(f_csb), .sram_web0(f_web), .sram_wmask0(f_wmask),
    .sram_addr0(f_addr), .sram_din0(f_din), .sram_dout0(f_dout)
  );

  // Behavioural macro: masked write, registered read.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (!a_csb) begin
      if (!a_web) begin
        for (int b = 0; b < 4; b++)
          if (a_wmask[b]) mem[a_addr][b*8 +: 8] <= a_din[b*8 +: 8];
      end else begin
        a_dout <= mem[a_addr];
      end
    end
  end

  always @(posedge clk) if (!f_csb) f_dout <= {24'h0, f_addr};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_word;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h20] = 32'hAABBCCDD;
    a_dout = 32'h0;

    // Reset state
    #2;
    check("rst_csb", {31'h0, a_csb}, 32'h1);
    check("rst_web", {31'h0, a_web}, 32'h1);
    check("rst_addr", {24'h0, a_addr}, 32'h0);
    check("rst_rvalid", {30'h0, a0_rvalid, a1_rvalid}, 32'h0);
    tick; tick;
    rst = 1'b0;
    tick;

    // Single read by r0
    a0_req = 1; a0_we = 0; a0_addr = 8'h10;
    #1;
    check("rd_gnt", {30'h0, a0_gnt, a1_gnt}, 32'h2);
    check("rd_ctrl", {30'h0, a_csb, a_web}, 32'h1);
    check("rd_addr", {24'h0, a_addr}, 32'h10);
    tick;
    a0_req = 0;
    check("rd_rvalid", {30'h0, a0_rvalid, a1_rvalid}, 32'h2);
    check("rd_data", a0_rdata, 32'hDEADBEEF);
    tick;
    check("rd_rvalid_drop", {31'h0, a0_rvalid}, 32'h0);

    // Round-robin alternation from reset
    rst = 1; #1; rst = 0;
    a0_req = 1; a0_addr = 8'h10;
    a1_req = 1; a1_we = 0; a1_addr = 8'h20;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_gnt", {30'h0, a0_gnt, a1_gnt}, (i % 2 == 0) ? 32'h2 : 32'h1);
      tick;
      check("rr_rvalid", {30'h0, a0_rvalid, a1_rvalid}, (i % 2 == 0) ? 32'h2 : 32'h1);
      exp_word = (i % 2 == 0) ? 32'hDEADBEEF : 32'hAABBCCDD;
      check("rr_rdata", (i % 2 == 0) ? a0_rdata : a1_rdata, exp_word);
    end
    a0_req = 0; a1_req = 0;
    tick;

    // Masked write by r1, then read back through r0
    a1_req = 1; a1_we = 1; a1_wmask = 4'b0011; a1_addr = 8'h20; a1_wdata = 32'h12345678;
    #1;
    check("wr_gnt", {31'h0, a1_gnt}, 32'h1);
    check("wr_web", {31'h0, a_web}, 32'h0);
    check("wr_mask", {28'h0, a_wmask}, 32'h3);
    check("wr_din", a_din, 32'h12345678);
    tick;
    a1_req = 0;
    check("wr_no_rvalid", {30'h0, a0_rvalid, a1_rvalid}, 32'h0);
    a0_req = 1; a0_we = 0; a0_addr = 8'h20;
    tick;
    a0_req = 0;
    check("wr_readback", a0_rdata, 32'hAABB5678);
    check("wr_readback_v", {30'h0, a0_rvalid, a1_rvalid}, 32'h2);
    tick;

    // Lock held by r1 across idle cycles
    a1_req = 1; a1_we = 1; a1_lock = 1; a1_wmask = 4'hF; a1_addr = 8'h30; a1_wdata = 32'h0BADF00D;
    #1;
    check("lk_gnt1", {31'h0, a1_gnt}, 32'h1);
    tick;
    a1_req = 0; a1_we = 0;
    a0_req = 1; a0_addr = 8'h10;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("lk_block", {30'h0, a0_gnt, a_csb}, 32'h1);
      tick;
    end
    a1_lock = 0;
    #1;
    check("lk_release", {30'h0, a0_gnt, a_csb}, 32'h2);
    tick;
    a0_req = 0;
    check("lk_rd_data", a0_rdata, 32'hDEADBEEF);
    tick;

    // Reset in the cycle after a granted read
    a0_req = 1; a0_addr = 8'h10;
    tick;
    rst = 1;
    #1;
    check("rst_mid_rvalid", {31'h0, a0_rvalid}, 32'h0);
    check("rst_mid_csb", {30'h0, a_csb, a0_gnt}, 32'h2);
    #1;
    rst = 0; a0_req = 0;
    tick;
    check("rst_no_spurious", {30'h0, a0_rvalid, a1_rvalid}, 32'h0);
    a0_req = 1; a1_req = 1; a1_we = 0;
    #1;
    check("rst_rr_ptr", {30'h0, a0_gnt, a1_gnt}, 32'h2);
    a0_req = 0; a1_req = 0;
    tick;

    // Fixed priority with starvation limit 3
    f0_req = 1; f1_req = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("fp_gnt", {30'h0, f0_gnt, f1_gnt}, (i % 4 == 3) ? 32'h1 : 32'h2);
      tick;
      check("fp_rvalid", {30'h0, f0_rvalid, f1_rvalid}, (i % 4 == 3) ? 32'h1 : 32'h2);
      check("fp_rdata", f1_rdata, (i % 4 == 3) ? 32'h2 : 32'h1);
    end
    f0_req = 0; f1_req = 0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sram_port_arbiter

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares the single 1RW port (port 0) of one sky130_sram_1kbyte_1rw1r_32x256_8 macro between two requesters: requester 0 (core fetch/LSU) and requester 1 (Wishbone loader/debug).
- Arbitrates every cycle, drives the macro's active-low csb0/web0 controls, and routes the read response back to the granted requester.
- Supports optional atomic lock and starvation protection.
- Instantiated once per shared macro (iram A/B, dram) between the core and the macro.

Parameters:
- AW, 8, SRAM word-address width (256 words).
- FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = requester 0 always has priority, subject to STARVE_LIMIT.
- STARVE_LIMIT, 8, in FIXED_PRIO mode, the number of consecutive denied cycles for requester 1 before its grant is forced (range 1..255).

Ports:
- clk  in  1  clock; also drives the macro's clk0 externally.
- wb_rst_i  in  1  asynchronous active-high reset.
- rN_req  in  1  access request (N = 0, 1).
- rN_we  in  1  1 = write, 0 = read.
- rN_lock  in  1  hold ownership after this access.
- rN_wmask  in  4  byte write enables.
- rN_addr  in  AW  word address.
- rN_wdata  in  32  write data.
- rN_gnt  out  1  access accepted this cycle (combinational).
- rN_rvalid  out  1  read data valid (registered).
- rN_rdata  out  32  read data.
- sram_csb0  out  1  macro chip select, active low.
- sram_web0  out  1  macro write enable, active low.
- sram_wmask0  out  4  macro byte write mask.
- sram_addr0  out  AW  macro address.
- sram_din0  out  32  macro write data.
- sram_dout0  in  32  macro read data, valid the cycle after a read is sampled.

Behaviour:
- Reset (asynchronous, wb_rst_i high):
  - rr_ptr = 0 (requester 0 favoured first).
  - lock_own = none; starve_cnt = 0.
  - rN_rvalid = 0; pending read dropped.
  - Macro outputs idle: csb0 = 1, web0 = 1, mask/addr/din = 0.
- Grant selection is combinational in the same cycle; evaluate in this order:
  1. Lock: if lock_own = N, only requester N may be granted, even if the other requester is requesting or N is idle.
  2. Starvation (FIXED_PRIO = 1 only): if starve_cnt = STARVE_LIMIT and r1_req, grant r1.
  3. Single requester: grant it.
  4. Both requesting: round-robin grants requester rr_ptr; fixed priority grants r0.
- Exactly one gnt at most per cycle; a gnt is never asserted without the matching req.
- Macro drive:
  - Granted: csb0 = 0, web0 = ~we, and mask/addr/din are muxed from the winner.
  - No grant: idle values as at reset.
- Writes: gnt is completion; no response is generated.
- Reads: rN_rvalid = 1 exactly one cycle after a granted read by N, for one cycle.
  - Both rN_rdata = sram_dout0 unconditionally; consumers qualify with rvalid.
  - Back-to-back reads give one rvalid per cycle, so full throughput is one access per clock.
- rr_ptr: after a grant to N, rr_ptr = ~N. It is unchanged on idle cycles.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each cycle with r1_req=1 and r1_gnt=0.
  - Clears on r1_gnt or when r1_req=0.
  - Held at 0 when FIXED_PRIO = 0.
- Lock:
  - Set lock_own = N at any grant to N with rN_lock = 1.
  - Clear when the owner presents rN_lock = 0, whether or not it is requesting.
  - Starvation override never breaks a lock.
- Simultaneous events:
  - A lock release and a grant to the other requester may occur in the same cycle, because the owner's lock = 0 is evaluated combinationally.
  - Reset during a pending read: no rvalid is issued.

Decomposition:
- Shared package/defines file (alongside the existing IRAM/DRAM address-width defines): SRAM_DW = 32, SRAM_MASKW = 4, and requester index constants REQ_CORE = 0, REQ_HOST = 1.
- No sub-module is needed. Lock, starvation counter, rr_ptr and response-select registers are all local.

Test Plan:
- Reset, then r0 read addr 0x10 (macro word preloaded 0xDEADBEEF) -> r0_gnt=1 and csb0=0/web0=1/addr0=0x10 in cycle 0; r0_rvalid=1, r0_rdata=0xDEADBEEF in cycle 1; r1_rvalid stays 0.
- Both requesters continuously reading, FIXED_PRIO=0 -> grants alternate r0, r1, r0, r1 from reset; one rvalid per cycle, routed to the correct requester.
- FIXED_PRIO=1, STARVE_LIMIT=3, r0 and r1 requesting continuously -> r0 granted 3 cycles, r1 forced on the 4th, starve_cnt back to 0, pattern repeats.
- r1 write, wmask=4'b0011, wdata=0x12345678, addr 0x20 -> web0=0, wmask0=0011 in the grant cycle; a later r0 read of 0x20 returns the upper bytes unchanged and lower bytes 0x5678.
- r1 locked write (r1_lock=1) followed by 2 idle cycles while r0 requests -> r0_gnt=0 throughout; r1 drops lock -> r0_gnt=1 in that same cycle.
- Assert wb_rst_i in the cycle after a granted r0 read -> r0_rvalid=0 immediately, csb0=1; after deassertion rr_ptr=0 and no spurious rvalid.
